// File: rtl/census_line_sequencer.sv
// Frame/line sequencer for the 3-line census window datapath.
// Counts incoming luma pixels and rotates three line buffers modulo 3.
// Emits one census window per cycle in raster order, together with the
// buffer selects for the window rows and the image-border masks.
// The trailing columns of each line are emitted during horizontal blanking.
// The last image row is emitted after the final input line.
module census_line_sequencer #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned HALF_W = 7,
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          de,
    output logic          wr_en,
    output logic [1:0]    wr_sel,
    output logic [XW-1:0] wr_addr,
    output logic [1:0]    rd_top_sel,
    output logic [1:0]    rd_mid_sel,
    output logic [1:0]    rd_bot_sel,
    output logic [XW-1:0] ctr_x,
    output logic [YW-1:0] ctr_y,
    output logic          win_valid,
    output logic          mask_top,
    output logic          mask_bot,
    output logic          mask_left,
    output logic          mask_right,
    output logic          frame_done,
    output logic          err_overrun
);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_HALF  = XW'(HALF_W);
    localparam logic [XW-1:0] X_TAIL0 = XW'(IMG_W - HALF_W);
    localparam logic [XW-1:0] X_TLAST = XW'(HALF_W - 1);
    localparam logic [XW-1:0] X_RCLIP = XW'(IMG_W - 1 - HALF_W);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_TAIL,
        S_FLUSH
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_in_q, x_in_d;
    logic [YW-1:0] y_in_q, y_in_d;
    logic [1:0]    cur_q, cur_d;
    logic [XW-1:0] tail_cnt_q, tail_cnt_d;
    logic [XW-1:0] flush_x_q, flush_x_d;
    logic          err_q, err_d;
    logic          done_pend_q, done_pend_d;

    logic          emit_c;
    logic [XW-1:0] ex_c;
    logic [YW-1:0] ey_c;

    logic          win_valid_q;
    logic [XW-1:0] ctr_x_q;
    logic [YW-1:0] ctr_y_q;
    logic          mask_top_q, mask_bot_q, mask_left_q, mask_right_q;
    logic [1:0]    rd_top_q, rd_mid_q, rd_bot_q;
    logic          frame_done_q;

    // Next line buffer index, wrapping 2 -> 0.
    function automatic logic [1:0] inc3(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Next-state and window-emit decode.
    always_comb begin
        state_d     = state_q;
        x_in_d      = x_in_q;
        y_in_d      = y_in_q;
        cur_d       = cur_q;
        tail_cnt_d  = tail_cnt_q;
        flush_x_d   = flush_x_q;
        err_d       = err_q;
        done_pend_d = 1'b0;
        emit_c      = 1'b0;
        ex_c        = '0;
        ey_c        = '0;

        if (vsync) begin
            state_d = S_FILL;
            x_in_d  = '0;
            y_in_d  = '0;
            cur_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_FILL, S_RUN: begin
                    if (de) begin
                        x_in_d = (x_in_q == X_LAST) ? '0 : x_in_q + 1'b1;
                        if (state_q == S_RUN && x_in_q >= X_HALF) begin
                            emit_c = 1'b1;
                            ex_c   = x_in_q - X_HALF;
                            ey_c   = y_in_q - 1'b1;
                        end
                        if (x_in_q == X_LAST) begin
                            if (state_q == S_FILL) begin
                                cur_d   = inc3(cur_q);
                                y_in_d  = YW'(1);
                                state_d = S_RUN;
                            end else begin
                                tail_cnt_d = '0;
                                state_d    = S_TAIL;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    // A pixel here belongs to the next line and is dropped.
                    emit_c     = 1'b1;
                    ex_c       = X_TAIL0 + tail_cnt_q;
                    ey_c       = y_in_q - 1'b1;
                    tail_cnt_d = tail_cnt_q + 1'b1;
                    if (de) begin
                        err_d = 1'b1;
                    end
                    if (tail_cnt_q == X_TLAST) begin
                        cur_d  = inc3(cur_q);
                        y_in_d = y_in_q + 1'b1;
                        if (y_in_q == Y_LAST) begin
                            flush_x_d = '0;
                            state_d   = S_FLUSH;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_FLUSH: begin
                    emit_c    = 1'b1;
                    ex_c      = flush_x_q;
                    ey_c      = Y_LAST;
                    flush_x_d = flush_x_q + 1'b1;
                    if (de) begin
                        err_d = 1'b1;
                    end
                    if (flush_x_q == X_LAST) begin
                        done_pend_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_in_q       <= '0;
            y_in_q       <= '0;
            cur_q        <= '0;
            tail_cnt_q   <= '0;
            flush_x_q    <= '0;
            err_q        <= 1'b0;
            done_pend_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            ctr_x_q      <= '0;
            ctr_y_q      <= '0;
            mask_top_q   <= 1'b0;
            mask_bot_q   <= 1'b0;
            mask_left_q  <= 1'b0;
            mask_right_q <= 1'b0;
            rd_top_q     <= '0;
            rd_mid_q     <= '0;
            rd_bot_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_in_q       <= x_in_d;
            y_in_q       <= y_in_d;
            cur_q        <= cur_d;
            tail_cnt_q   <= tail_cnt_d;
            flush_x_q    <= flush_x_d;
            err_q        <= err_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= done_pend_q;
            win_valid_q  <= emit_c;
            if (emit_c) begin
                ctr_x_q      <= ex_c;
                ctr_y_q      <= ey_c;
                mask_top_q   <= (ey_c == '0);
                mask_bot_q   <= (ey_c == Y_LAST);
                mask_left_q  <= (ex_c < X_HALF);
                mask_right_q <= (ex_c > X_RCLIP);
                rd_bot_q     <= cur_q;
                rd_mid_q     <= inc3(inc3(cur_q));
                rd_top_q     <= inc3(cur_q);
            end
        end
    end

    assign wr_en       = de && (state_q == S_FILL || state_q == S_RUN);
    assign wr_sel      = cur_q;
    assign wr_addr     = x_in_q;
    assign rd_top_sel  = rd_top_q;
    assign rd_mid_sel  = rd_mid_q;
    assign rd_bot_sel  = rd_bot_q;
    assign ctr_x       = ctr_x_q;
    assign ctr_y       = ctr_y_q;
    assign win_valid   = win_valid_q;
    assign mask_top    = mask_top_q;
    assign mask_bot    = mask_bot_q;
    assign mask_left   = mask_left_q;
    assign mask_right  = mask_right_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_census_line_sequencer.sv
// Directed bench for census_line_sequencer: a small 16x4 instance and two
// default 320x240 instances sharing one pixel stream.
module tb_census_line_sequencer;

    localparam int XW  = 10;
    localparam int YW  = 8;
    localparam int AW  = 320;
    localparam int AH  = 240;
    localparam int AHW = 7;
    localparam int SW  = 16;
    localparam int SH  = 4;
    localparam int SHW = 2;
    localparam int ROW5_BUF = 5 % 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default-size instances A and B (B gets an extra mid-frame vsync)
    logic rst_ab, vsync_a, vsync_b, de_ab;
    logic a_wr_en, a_win_valid, a_mask_top, a_mask_bot, a_mask_left, a_mask_right, a_frame_done, a_err_overrun;
    logic [1:0] a_wr_sel, a_rd_top_sel, a_rd_mid_sel, a_rd_bot_sel;
    logic [XW-1:0] a_wr_addr, a_ctr_x;
    logic [YW-1:0] a_ctr_y;
    logic b_wr_en, b_win_valid, b_mask_top, b_mask_bot, b_mask_left, b_mask_right, b_frame_done, b_err_overrun;
    logic [1:0] b_wr_sel, b_rd_top_sel, b_rd_mid_sel, b_rd_bot_sel;
    logic [XW-1:0] b_wr_addr, b_ctr_x;
    logic [YW-1:0] b_ctr_y;
    // Small instance S
    logic rst_s, vsync_s, de_s;
    logic s_wr_en, s_win_valid, s_mask_top, s_mask_bot, s_mask_left, s_mask_right, s_frame_done, s_err_overrun;
    logic [1:0] s_wr_sel, s_rd_top_sel, s_rd_mid_sel, s_rd_bot_sel;
    logic [XW-1:0] s_wr_addr, s_ctr_x;
    logic [YW-1:0] s_ctr_y;

    census_line_sequencer #(.IMG_W(AW), .IMG_H(AH), .HALF_W(AHW), .XW(XW), .YW(YW)) u_a (
        .clk(clk), .rst(rst_ab), .vsync(vsync_a), .de(de_ab),
        .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_addr(a_wr_addr),
        .rd_top_sel(a_rd_top_sel), .rd_mid_sel(a_rd_mid_sel), .rd_bot_sel(a_rd_bot_sel),
        .ctr_x(a_ctr_x), .ctr_y(a_ctr_y), .win_valid(a_win_valid),
        .mask_top(a_mask_top), .mask_bot(a_mask_bot), .mask_left(a_mask_left), .mask_right(a_mask_right),
        .frame_done(a_frame_done), .err_overrun(a_err_overrun)
    );

    census_line_sequencer #(.IMG_W(AW), .IMG_H(AH), .HALF_W(AHW), .XW(XW), .YW(YW)) u_b (
        .clk(clk), .rst(rst_ab), .vsync(vsync_b), .de(de_ab),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_addr(b_wr_addr),
        .rd_top_sel(b_rd_top_sel), .rd_mid_sel(b_rd_mid_sel), .rd_bot_sel(b_rd_bot_sel),
        .ctr_x(b_ctr_x), .ctr_y(b_ctr_y), .win_valid(b_win_valid),
        .mask_top(b_mask_top), .mask_bot(b_mask_bot), .mask_left(b_mask_left), .mask_right(b_mask_right),
        .frame_done(b_frame_done), .err_overrun(b_err_overrun)
    );

    census_line_sequencer #(.IMG_W(SW), .IMG_H(SH), .HALF_W(SHW), .XW(XW), .YW(YW)) u_s (
        .clk(clk), .rst(rst_s), .vsync(vsync_s), .de(de_s),
        .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr),
        .rd_top_sel(s_rd_top_sel), .rd_mid_sel(s_rd_mid_sel), .rd_bot_sel(s_rd_bot_sel),
        .ctr_x(s_ctr_x), .ctr_y(s_ctr_y), .win_valid(s_win_valid),
        .mask_top(s_mask_top), .mask_bot(s_mask_bot), .mask_left(s_mask_left), .mask_right(s_mask_right),
        .frame_done(s_frame_done), .err_overrun(s_err_overrun)
    );

    // Raster-order window model state
    int a_ex = 0, a_ey = 0, a_nwin = 0;
    int s_ex = 0, s_ey = 0, s_nwin = 0;
    int b_nwin = 0, b_px = -1, b_win_fill = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {pad, y, x, top, bot, left, right} for window (x,y)
    function automatic logic [31:0] win_vec(input int x, input int y, input int w, input int h, input int hw);
        return {10'd0, 8'(y), 10'(x), (y == 0), (y == h - 1), (x < hw), (x > w - 1 - hw)};
    endfunction

    // {top, mid, bot}: centre row r lives in buffer r%3
    function automatic logic [31:0] sel_vec(input int y);
        return 32'({2'((y + 2) % 3), 2'(y % 3), 2'((y + 1) % 3)});
    endfunction

    function automatic logic distinct3(input logic [1:0] t, input logic [1:0] m, input logic [1:0] b);
        return (t != m) && (t != b) && (m != b) && (t != 2'd3) && (m != 2'd3) && (b != 2'd3);
    endfunction

    // One clock, then sample and score any emitted windows
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_win_valid) begin
            chk("a_win", 32'({a_ctr_y, a_ctr_x, a_mask_top, a_mask_bot, a_mask_left, a_mask_right}),
                win_vec(a_ex, a_ey, AW, AH, AHW));
            chk("a_sel", 32'({a_rd_top_sel, a_rd_mid_sel, a_rd_bot_sel}), sel_vec(a_ey));
            chk("a_sel_distinct", 32'(distinct3(a_rd_top_sel, a_rd_mid_sel, a_rd_bot_sel)), 32'd1);
            if (a_ctr_y == YW'(5)) chk("a_mid_row5", 32'(a_rd_mid_sel), 32'(ROW5_BUF));
            a_nwin++;
            a_ex++;
            if (a_ex == AW) begin a_ex = 0; a_ey++; end
        end
        if (s_win_valid) begin
            chk("s_win", 32'({s_ctr_y, s_ctr_x, s_mask_top, s_mask_bot, s_mask_left, s_mask_right}),
                win_vec(s_ex, s_ey, SW, SH, SHW));
            chk("s_sel", 32'({s_rd_top_sel, s_rd_mid_sel, s_rd_bot_sel}), sel_vec(s_ey));
            s_nwin++;
            s_ex++;
            if (s_ex == SW) begin s_ex = 0; s_ey++; end
        end
        if (b_win_valid) b_nwin++;
    endtask

    // Small 16x4 frame with 4-cycle horizontal blanking
    task automatic s_frame();
        vsync_s = 1'b1; s_ex = 0; s_ey = 0; s_nwin = 0;
        tick();
        vsync_s = 1'b0;
        for (int l = 0; l < SH; l++) begin
            for (int x = 0; x < SW; x++) begin
                de_s = 1'b1;
                tick();
                if (l == 1 && x == 1) chk("s_no_early_win", 32'(s_win_valid), 32'd0);
                if (l == 1 && x == 2)
                    chk("s_first_win", 32'({s_win_valid, s_ctr_x, s_ctr_y, s_mask_top, s_mask_left}),
                        32'({1'b1, 10'd0, 8'd0, 1'b1, 1'b1}));
            end
            de_s = 1'b0;
            repeat (4) tick();
        end
    endtask

    // One default-size input line plus 8 blanking cycles
    task automatic a_line(input int l);
        for (int x = 0; x < AW; x++) begin
            if (l == 100 && x == 160) begin
                de_ab = 1'b0; vsync_b = 1'b1; b_nwin = 0;
                tick();
                vsync_b = 1'b0; b_px = 0;
                chk("b_vsync_err_clear", 32'(b_err_overrun), 32'd0);
            end
            de_ab = 1'b1;
            if (x == 0) begin
                #1;
                chk("a_line_start", 32'({a_wr_en, a_wr_sel, a_wr_addr}), 32'({1'b1, 2'(l % 3), 10'd0}));
                chk("a_err_hold", 32'(a_err_overrun), 32'(l > 3));
            end
            tick();
            if (b_px >= 0) begin
                b_px++;
                if (b_px == AW) b_win_fill = b_nwin;
            end
        end
        de_ab = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (l == 3 && b == 2) begin
                de_ab = 1'b1;
                #1;
                chk("a_ovr_no_write", 32'(a_wr_en), 32'd0);
            end
            tick();
            de_ab = 1'b0;
            if (l == 3 && b < 7) begin
                chk("a_tail_win", 32'({a_win_valid, a_ctr_x, a_ctr_y, a_mask_right}),
                    32'({1'b1, 10'(313 + b), 8'd2, 1'b1}));
                chk("a_ovr_flag", 32'(a_err_overrun), 32'(b >= 2));
            end
        end
    endtask

    initial begin
        bit found;
        rst_ab = 1'b1; vsync_a = 1'b0; vsync_b = 1'b0; de_ab = 1'b0;
        rst_s = 1'b1; vsync_s = 1'b0; de_s = 1'b0;
        repeat (3) tick();
        rst_ab = 1'b0; rst_s = 1'b0;
        tick();

        // Reset state
        chk("a_rst_sel", 32'({a_wr_sel, a_wr_addr, a_rd_top_sel, a_rd_mid_sel, a_rd_bot_sel}), 32'd0);
        chk("a_rst_ctr", 32'({a_ctr_x, a_ctr_y}), 32'd0);
        chk("a_rst_flags", 32'({a_wr_en, a_win_valid, a_mask_top, a_mask_bot, a_mask_left, a_mask_right,
                                a_frame_done, a_err_overrun}), 32'd0);
        chk("s_rst_flags", 32'({s_wr_en, s_win_valid, s_frame_done, s_err_overrun, s_wr_sel}), 32'd0);

        // Small frame: count, first window, frame_done timing
        s_frame();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (s_win_valid && s_ctr_x == XW'(15) && s_ctr_y == YW'(3)) found = 1'b1;
        end
        chk("s_last_win_seen", 32'(found), 32'd1);
        tick();
        chk("s_done_pulse", 32'({s_frame_done, s_win_valid}), 32'b10);
        tick();
        chk("s_done_single", 32'(s_frame_done), 32'd0);
        chk("s_win_count", s_nwin, 32'(SW * SH));
        repeat (20) tick();

        // Small frame aborted by reset during the flush row
        s_frame();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (s_win_valid && s_ctr_x == XW'(5) && s_ctr_y == YW'(3)) found = 1'b1;
        end
        chk("s_flush_reached", 32'(found), 32'd1);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        chk("s_frst_sel", 32'({s_wr_sel, s_wr_addr, s_rd_top_sel, s_rd_mid_sel, s_rd_bot_sel}), 32'd0);
        chk("s_frst_ctr", 32'({s_ctr_x, s_ctr_y}), 32'd0);
        chk("s_frst_flags", 32'({s_wr_en, s_win_valid, s_mask_top, s_mask_bot, s_mask_left, s_mask_right,
                                 s_frame_done, s_err_overrun}), 32'd0);
        de_s = 1'b1;
        #1;
        chk("s_idle_no_write", 32'(s_wr_en), 32'd0);
        repeat (20) tick();
        de_s = 1'b0;
        chk("s_idle_quiet", 32'({s_win_valid, s_frame_done, s_err_overrun}), 32'd0);
        chk("s_win_count_rst", s_nwin, 32'(3 * SW + 6));

        // Default-size frame: rotation, tail, overrun, mid-frame vsync on B
        vsync_a = 1'b1; vsync_b = 1'b1; a_ex = 0; a_ey = 0; a_nwin = 0;
        tick();
        vsync_a = 1'b0; vsync_b = 1'b0;
        for (int l = 0; l < AH; l++) a_line(l);
        found = 1'b0;
        for (int i = 0; i < AW + 20 && !found; i++) begin
            tick();
            if (a_frame_done) found = 1'b1;
        end
        chk("a_frame_done_seen", 32'(found), 32'd1);
        chk("a_win_count", a_nwin, 32'(AW * AH));
        chk("a_err_sticky", 32'(a_err_overrun), 32'd1);
        chk("b_fill_no_win", b_win_fill, 32'd0);
        vsync_a = 1'b1;
        tick();
        vsync_a = 1'b0;
        chk("a_err_clear_vsync", 32'(a_err_overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
